// File: rtl/line_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// line_bus_arbiter_pkg
// Shared types and constants for the line bus arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT_RESP -> IDLE)
//   ARB_RR      : round-robin arbitration mode
//   ARB_FIXED   : fixed-priority arbitration mode, lowest channel index wins
// -----------------------------------------------------------------------------
package line_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/line_bus_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Purely combinational grant picker for the line bus arbiter.
// Ports:
//   req_i   : per-channel request vector
//   ptr_i   : index of the last granted channel (round-robin mode only)
//   fixed_i : 1 = fixed priority (lowest index wins), 0 = round-robin
//   grant_o : one-hot grant vector, all zero when nothing requests
//   idx_o   : index of the granted channel, 0 when nothing requests
//   any_o   : high when some channel was granted
// -----------------------------------------------------------------------------
module rr_grant #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] ptr_i,
    input  logic                      fixed_i,
    output logic [NUM_CH-1:0]         grant_o,
    output logic [$clog2(NUM_CH)-1:0] idx_o,
    output logic                      any_o
);

    localparam int IDX_W = $clog2(NUM_CH);

    int               cand;
    logic [IDX_W-1:0] candIdx;
    logic             found;

    // Walk the channels in priority order and keep the first requester.
    // Round-robin starts one past the last winner and wraps, so the most
    // recently served channel is always considered last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (fixed_i) begin
                cand = k;
            end else begin
                cand = (int'(ptr_i) + 1 + k) % NUM_CH;
            end
            candIdx = IDX_W'(cand);
            if (!found && req_i[candIdx]) begin
                found            = 1'b1;
                grant_o[candIdx] = 1'b1;
                idx_o            = candIdx;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/line_bus_arbiter.sv
// -----------------------------------------------------------------------------
// line_bus_arbiter
// Multiplexes NUM_CH upstream line-interface requesters onto one downstream
// line interface, one transaction outstanding at a time, and routes each
// response back to the channel that issued it.
// Parameters:
//   NUM_CH   : number of upstream channels (>= 2)
//   ADDR_W   : address width
//   LINE_W   : line width in bits
//   ARB_MODE : ARB_RR (round-robin) or ARB_FIXED (lowest index wins)
//   WR_RESP  : 1 = downstream answers writes with resp_valid,
//              0 = writes complete when downstream accepts them
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   up_req_valid/ready/rw     : per-channel request handshake and direction
//   up_req_addr/wline         : packed per-channel address / write line
//   up_resp_valid/rline       : per-channel response pulse, shared line
//   dn_req_valid/ready/rw     : downstream request handshake and direction
//   dn_req_addr/wline         : downstream address / write line (registered)
//   dn_resp_valid/rline       : downstream response
//   busy                      : high whenever a transaction is in progress
//   owner                     : channel being served, 0 when idle
// -----------------------------------------------------------------------------
module line_bus_arbiter
    import line_bus_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int ARB_MODE = ARB_RR,
    parameter int WR_RESP  = 0
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [NUM_CH-1:0]         up_req_valid,
    output logic [NUM_CH-1:0]         up_req_ready,
    input  logic [NUM_CH-1:0]         up_req_rw,
    input  logic [NUM_CH*ADDR_W-1:0]  up_req_addr,
    input  logic [NUM_CH*LINE_W-1:0]  up_req_wline,
    output logic [NUM_CH-1:0]         up_resp_valid,
    output logic [LINE_W-1:0]         up_resp_rline,

    output logic                      dn_req_valid,
    input  logic                      dn_req_ready,
    output logic                      dn_req_rw,
    output logic [ADDR_W-1:0]         dn_req_addr,
    output logic [LINE_W-1:0]         dn_req_wline,
    input  logic                      dn_resp_valid,
    input  logic [LINE_W-1:0]         dn_resp_rline,

    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] owner
);

    localparam int   IDX_W         = $clog2(NUM_CH);
    localparam logic FIXED_MODE    = (ARB_MODE == ARB_FIXED);
    localparam logic SYNTH_WR_DONE = (WR_RESP == 0);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [NUM_CH-1:0] respValid_q, respValid_d;
    logic [LINE_W-1:0] rline_q, rline_d;

    logic [NUM_CH-1:0] grantVec;
    logic [IDX_W-1:0]  grantIdx;
    logic              grantAny;
    logic [NUM_CH-1:0] ownerMask;

    rr_grant #(
        .NUM_CH (NUM_CH)
    ) u_grant (
        .req_i   (up_req_valid),
        .ptr_i   (ptr_q),
        .fixed_i (FIXED_MODE),
        .grant_o (grantVec),
        .idx_o   (grantIdx),
        .any_o   (grantAny)
    );

    // One-hot of the channel that owns the in-flight transaction, used to
    // steer the response pulse back to it.
    always_comb begin
        ownerMask          = '0;
        ownerMask[owner_q] = 1'b1;
    end

    // Next-state and upstream-ready logic. The response valid register
    // defaults to zero so every response is a single-cycle pulse. The
    // ready gate on rst keeps up_req_ready low while reset is held even
    // if requesters keep their valid bits up.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wline_d      = wline_q;
        respValid_d  = '0;
        rline_d      = rline_q;
        up_req_ready = '0;

        case (state_q)
            IDLE: begin
                if (grantAny && !rst) begin
                    up_req_ready = grantVec;
                    owner_d      = grantIdx;
                    rw_d         = up_req_rw[grantIdx];
                    addr_d       = up_req_addr[int'(grantIdx)*ADDR_W +: ADDR_W];
                    wline_d      = up_req_wline[int'(grantIdx)*LINE_W +: LINE_W];
                    if (!FIXED_MODE) begin
                        ptr_d = grantIdx;
                    end
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (dn_req_ready) begin
                    if (rw_q && SYNTH_WR_DONE) begin
                        respValid_d = ownerMask;
                        rline_d     = '0;
                        state_d     = IDLE;
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end
            end

            WAIT_RESP: begin
                if (dn_resp_valid) begin
                    respValid_d = ownerMask;
                    rline_d     = dn_resp_rline;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers. The pointer resets to the last channel
    // so the first round-robin search begins at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_CH - 1);
            owner_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wline_q     <= '0;
            respValid_q <= '0;
            rline_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wline_q     <= wline_d;
            respValid_q <= respValid_d;
            rline_q     <= rline_d;
        end
    end

    // Downstream fields come only from the capture registers, so they stay
    // stable for the whole ISSUE phase regardless of upstream activity.
    assign dn_req_valid  = (state_q == ISSUE);
    assign dn_req_rw     = rw_q;
    assign dn_req_addr   = addr_q;
    assign dn_req_wline  = wline_q;

    assign up_resp_valid = respValid_q;
    assign up_resp_rline = rline_q;

    assign busy  = (state_q != IDLE);
    assign owner = busy ? owner_q : '0;

endmodule

// File: doc/line_bus_arbiter.md
Name: line_bus_arbiter

Overview:
- N-channel arbiter multiplexing several upstream line-interface requesters (per-core L2s, DMA) onto one downstream line interface (shared L2 or main_mem).
- Uses the existing line protocol (req_valid/ready, rw, addr, wline; resp_valid, rline).
- Keeps one transaction outstanding and routes each response back to the owning channel.
- Selectable round-robin or fixed-priority arbitration; optional synthesised write completion.

Parameters:
- NUM_CH, 4, number of upstream channels (>=2)
- ADDR_W, 32, address width
- LINE_W, 256, line width in bits
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- WR_RESP, 0, 1 = downstream returns resp_valid for writes; 0 = writes complete on downstream acceptance

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- up_req_valid  in  NUM_CH  per-channel request valid
- up_req_ready  out  NUM_CH  per-channel request accept
- up_req_rw  in  NUM_CH  per-channel 0=readline, 1=writeline
- up_req_addr  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W]
- up_req_wline  in  NUM_CH*LINE_W  packed write lines
- up_resp_valid  out  NUM_CH  per-channel response pulse
- up_resp_rline  out  LINE_W  response line, shared by all channels, qualified by up_resp_valid
- dn_req_valid  out  1  downstream request valid
- dn_req_ready  in  1  downstream accept
- dn_req_rw  out  1  downstream rw
- dn_req_addr  out  ADDR_W  downstream address
- dn_req_wline  out  LINE_W  downstream write line
- dn_resp_valid  in  1  downstream response
- dn_resp_rline  in  LINE_W  downstream read line
- busy  out  1  high whenever state != IDLE
- owner  out  $clog2(NUM_CH)  channel currently granted; 0 when idle

Behaviour:
- Reset (async, any state): state=IDLE, rr pointer=NUM_CH-1, all outputs 0, captured request and any in-flight response discarded. Downstream shares rst.
- FSM IDLE -> ISSUE -> WAIT_RESP -> IDLE.
- IDLE:
  - winner = grant(up_req_valid); up_req_ready[winner]=1 combinationally, same cycle. Only one ready bit high at any time.
  - On handshake: capture rw/addr/wline/owner into registers, go to ISSUE.
  - up_req_ready is 0 in every other state.
- Round-robin: search starts at ptr+1 mod NUM_CH, wrapping; ptr <= winner on grant.
- Fixed priority: lowest-index valid channel wins; ptr unused.
- ISSUE:
  - dn_req_valid=1 with registered fields, held stable until dn_req_ready.
  - On accept, if rw=0 or WR_RESP=1, go to WAIT_RESP.
  - On accept, if rw=1 and WR_RESP=0, pulse up_resp_valid[owner] next cycle with rline=0 and go to IDLE.
- WAIT_RESP:
  - On dn_resp_valid, register rline, assert up_resp_valid[owner] for exactly one cycle (next cycle), go to IDLE.
  - dn_resp_valid in IDLE or ISSUE is ignored.
- Latency:
  - upstream handshake at cycle N -> dn_req_valid first high at N+1.
  - dn_resp_valid at M -> up_resp_valid at M+1.
  - A new grant is possible at M+1, overlapping the response pulse.
- up_resp_rline holds its last value between pulses; only the owner's valid bit ever pulses.
- A channel deasserting up_req_valid before grant is legal and is never granted.
- Downstream fields are never driven from unregistered upstream inputs.

Decomposition:
- cache_pkg additions: arb_state_e {IDLE, ISSUE, WAIT_RESP}; localparams ARB_RR=0, ARB_FIXED=1.
- Sub-module rr_grant: combinational request vector + pointer + mode -> one-hot grant and index.
- FSM, capture registers and response routing stay in line_bus_arbiter.

Test Plan:
- Single read:
  - Stimulus: ch2 read addr 0x0000_0040; downstream ready immediately, resp 5 cycles later with rline 0xA5...A5.
  - Required: up_req_ready[2] same cycle; dn_req_addr=0x40 next cycle; up_resp_valid=4'b0100 for one cycle with rline 0xA5...A5.
- Round-robin fairness (ARB_MODE=0):
  - Stimulus: all 4 channels hold reads continuously from reset.
  - Required: grant order 0,1,2,3,0,1; no channel granted twice before the others.
- Fixed priority (ARB_MODE=1):
  - Stimulus: ch0 and ch3 both always valid.
  - Required: ch0 always wins; ch3 granted only after ch0 drops valid.
- Write completion:
  - Stimulus: WR_RESP=0, ch1 write 0x100, wline 0x1234...; dn_req_ready low 3 cycles.
  - Required: dn fields stable for 3 cycles; up_resp_valid[1] one cycle after acceptance; no WAIT_RESP.
  - Repeat with WR_RESP=1: completion waits for dn_resp_valid.
- Back-to-back:
  - Stimulus: ch0 read completes at cycle M; ch1 valid throughout.
  - Required: up_resp_valid[0] and up_req_ready[1] both high at M+1.
- Reset mid-op:
  - Stimulus: assert rst during WAIT_RESP, then drive dn_resp_valid after release.
  - Required: all outputs 0 immediately; stale resp ignored; next grant from a round-robin search starting at ch0.
